pea_ctrl_kxk: RTL and testbench

- Next-generation PE-array sequencing controller. Generalises the 1x1 controller to KxK kernels, strides 1/2/4 and shortened partial-tile passes.
- Adds a data_ready stall handshake from the ifm/wgt buffers.
- Sits between the layer-config registers and the PE array / buffer address generators. Drives buffer reads, per-column PE valid and loop-completion pulses.

---
 rtl/pea_ctrl_kxk.sv | 158 +++++++++++++++
 tb/tb_pea_ctrl_kxk.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_ctrl_kxk.sv
// pea_ctrl_kxk: PE-array sequencing controller for KxK kernels, strides 1/2/4 and partial tiles.
// Define PEA_CTRL_PERF_EN to build the stall-cycle counter on perf_stall_cnt (tied to 0 otherwise).
//
// state | meaning
// IDLE  | waiting for start_conv
// FLUSH | fetch weight vector and first ifm word for the next pass
// CALC  | stream the pixel columns of one pass into the PE array
module pea_ctrl_kxk #(
  parameter int COL           = 8,
  parameter int TILE_LEN      = 16,
  parameter int CHN_WIDTH     = 4,
  parameter int CHN_OFT_WIDTH = 6,
  parameter int KER_WIDTH     = 2,
  parameter int TC_ROW_WIDTH  = 6,
  parameter int TC_COL_WIDTH  = 6,
  parameter int PC_COL_WIDTH  = 4,
  parameter int PC_ROW_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHN_WIDTH-1:0]    chi,
  input  logic [CHN_WIDTH-1:0]    cho,
  input  logic [KER_WIDTH-1:0]    ker_size,
  input  logic [1:0]              stride_log2,
  input  logic                    start_conv,
  input  logic                    data_ready,
  input  logic [PC_ROW_WIDTH-1:0] tile_row_offset,
  input  logic [PC_COL_WIDTH-1:0] tile_col_offset,
  input  logic [TC_ROW_WIDTH-1:0] tc_row_max,
  input  logic [TC_COL_WIDTH-1:0] tc_col_max,
  output logic                    ifm_read,
  output logic                    wgt_read,
  output logic [COL-1:0]          pvalid,
  output logic [KER_WIDTH-1:0]    ker_row,
  output logic [KER_WIDTH-1:0]    ker_col,
  output logic                    ic_done,
  output logic                    tap_done,
  output logic                    oc_done,
  output logic                    conv_done,
  output logic                    busy,
  output logic [31:0]             perf_stall_cnt
);
  localparam int ICW = CHN_WIDTH + CHN_OFT_WIDTH;

  typedef enum logic [1:0] {IDLE, FLUSH, CALC} state_t;
  state_t state;

  logic [PC_COL_WIDTH-1:0] pc_col;
  logic [ICW-1:0]          ic_cnt, oc_cnt;
  logic [TC_COL_WIDTH-1:0] tc_col;
  logic [TC_ROW_WIDTH-1:0] tc_row;

  logic [ICW-1:0]          ic_num, oc_num;
  logic [KER_WIDTH-1:0]    ker_max;
  logic [PC_COL_WIDTH-1:0] pc_max;
  logic [1:0]              stride_eff;
  logic [COL-1:0]          row_msk;
  logic stride_hit, cnt_valid, pc_col_last, ic_last, oc_last;
  logic kc_last, kr_last, tap_last, tc_col_last, tc_row_last, tile_done;

  // A group count of 0 wraps to the full channel range through the subtraction.
  assign ic_num     = {chi, {CHN_OFT_WIDTH{1'b0}}} - ICW'(1);
  assign oc_num     = {cho, {CHN_OFT_WIDTH{1'b0}}} - ICW'(1);
  assign ker_max    = (ker_size == '0) ? '0 : ker_size - KER_WIDTH'(1);
  assign pc_max     = (tc_col == tc_col_max && tile_col_offset != '0) ?
                      tile_col_offset - PC_COL_WIDTH'(1) : PC_COL_WIDTH'(TILE_LEN - 1);
  assign stride_eff = (stride_log2 == 2'd3) ? 2'd2 : stride_log2;

  always_comb begin
    case (stride_eff)
      2'd0:    stride_hit = 1'b1;
      2'd1:    stride_hit = (pc_col[0] == 1'b0);
      default: stride_hit = (pc_col[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    row_msk = '1;
    if (tc_row == tc_row_max && tile_row_offset != '0)
      for (int i = 0; i < COL; i++) row_msk[i] = (i < int'(tile_row_offset));
  end

  assign cnt_valid   = (state == CALC) & data_ready;
  assign pc_col_last = (pc_col == pc_max);
  assign ic_last     = (ic_cnt == ic_num);
  assign oc_last     = (oc_cnt == oc_num);
  assign kc_last     = (ker_col == ker_max);
  assign kr_last     = (ker_row == ker_max);
  assign tap_last    = kc_last & kr_last;
  assign tc_col_last = (tc_col == tc_col_max);
  assign tc_row_last = (tc_row == tc_row_max);

  assign ic_done   = cnt_valid & pc_col_last;
  assign tap_done  = ic_done & ic_last;
  assign oc_done   = tap_done & tap_last;
  assign tile_done = oc_done & oc_last;
  assign conv_done = tile_done & tc_col_last & tc_row_last;

  assign wgt_read = (state == FLUSH) & data_ready;
  assign ifm_read = data_ready & ((state == FLUSH) | ((state == CALC) & ~pc_col_last));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_col  <= '0;
      ic_cnt  <= '0;
      oc_cnt  <= '0;
      ker_col <= '0;
      ker_row <= '0;
      tc_col  <= '0;
      tc_row  <= '0;
      pvalid  <= '0;
    end else begin
      // pvalid is the registered image of this cycle's column acceptance
      pvalid <= (cnt_valid & stride_hit) ? row_msk : '0;
      case (state)
        IDLE:    if (start_conv) state <= FLUSH;
        FLUSH:   if (data_ready) state <= CALC;
        CALC: begin
          if (conv_done)    state <= IDLE;
          else if (ic_done) state <= FLUSH;
        end
        default: state <= IDLE;
      endcase
      if (cnt_valid) pc_col <= pc_col_last ? '0 : pc_col + PC_COL_WIDTH'(1);
      if (ic_done)   ic_cnt <= ic_last ? '0 : ic_cnt + ICW'(1);
      if (tap_done) begin
        ker_col <= kc_last ? '0 : ker_col + KER_WIDTH'(1);
        if (kc_last) ker_row <= kr_last ? '0 : ker_row + KER_WIDTH'(1);
      end
      if (oc_done) oc_cnt <= oc_last ? '0 : oc_cnt + ICW'(1);
      if (tile_done) begin
        tc_col <= tc_col_last ? '0 : tc_col + TC_COL_WIDTH'(1);
        if (tc_col_last) tc_row <= tc_row_last ? '0 : tc_row + TC_ROW_WIDTH'(1);
      end
    end
  end

`ifdef PEA_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (start_conv) stall_cnt <= '0;
    end else if (!data_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pea_ctrl_kxk.sv
// Bench for pea_ctrl_kxk: per-cycle compare against a pass-list model, plus whole-layer count vectors.
module tb_pea_ctrl_kxk;
  localparam int COL = 8, TILE_LEN = 16, CHN_WIDTH = 4, CHN_OFT_WIDTH = 1, KER_WIDTH = 2;
  localparam int TC_ROW_WIDTH = 6, TC_COL_WIDTH = 6, PC_COL_WIDTH = 4, PC_ROW_WIDTH = 4;
`ifdef PEA_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start_conv, data_ready;
  logic [CHN_WIDTH-1:0] chi, cho;
  logic [KER_WIDTH-1:0] ker_size;
  logic [1:0] stride_log2;
  logic [PC_ROW_WIDTH-1:0] tile_row_offset;
  logic [PC_COL_WIDTH-1:0] tile_col_offset;
  logic [TC_ROW_WIDTH-1:0] tc_row_max;
  logic [TC_COL_WIDTH-1:0] tc_col_max;
  logic ifm_read, wgt_read, ic_done, tap_done, oc_done, conv_done, busy;
  logic [COL-1:0] pvalid;
  logic [KER_WIDTH-1:0] ker_row, ker_col;
  logic [31:0] perf_stall_cnt;

  pea_ctrl_kxk #(.COL(COL), .TILE_LEN(TILE_LEN), .CHN_WIDTH(CHN_WIDTH),
    .CHN_OFT_WIDTH(CHN_OFT_WIDTH), .KER_WIDTH(KER_WIDTH), .TC_ROW_WIDTH(TC_ROW_WIDTH),
    .TC_COL_WIDTH(TC_COL_WIDTH), .PC_COL_WIDTH(PC_COL_WIDTH), .PC_ROW_WIDTH(PC_ROW_WIDTH)) dut (
    .clk(clk), .rst(rst), .chi(chi), .cho(cho), .ker_size(ker_size), .stride_log2(stride_log2),
    .start_conv(start_conv), .data_ready(data_ready), .tile_row_offset(tile_row_offset),
    .tile_col_offset(tile_col_offset), .tc_row_max(tc_row_max), .tc_col_max(tc_col_max),
    .ifm_read(ifm_read), .wgt_read(wgt_read), .pvalid(pvalid), .ker_row(ker_row),
    .ker_col(ker_col), .ic_done(ic_done), .tap_done(tap_done), .oc_done(oc_done),
    .conv_done(conv_done), .busy(busy), .perf_stall_cnt(perf_stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int len; int kr; int kc;
    bit tap_end; bit oc_end; bit tile_end; bit conv_end;
    logic [COL-1:0] msk;
  } pass_t;

  typedef struct {
    logic [3:0] chi; logic [3:0] cho; logic [1:0] ker; logic [1:0] sl;
    logic [5:0] trm; logic [5:0] tcm; logic [3:0] tro; logic [3:0] tco;
    int busy; int ifm; int wgt; int pv; int part; int tap; int oc;
  } vec_t;

  pass_t passes[$];
  int step;
  bit m_busy, m_stream;
  int m_p, m_px, m_stall;
  logic [COL-1:0] m_pv;
  int checks = 0, failures = 0;
  int n_busy, n_ifm, n_wgt, n_pv, n_part, n_tap, n_oc, n_conv;

  // Expand the layer into the ordered list of pixel passes it must produce.
  task automatic build();
    int icn, ocn, k, len;
    logic [COL-1:0] msk;
    passes.delete();
    icn  = (chi == 0 ? (1 << CHN_WIDTH) : int'(chi)) * (1 << CHN_OFT_WIDTH);
    ocn  = (cho == 0 ? (1 << CHN_WIDTH) : int'(cho)) * (1 << CHN_OFT_WIDTH);
    k    = (ker_size == 0) ? 1 : int'(ker_size);
    step = 1 << ((stride_log2 == 2'd3) ? 2 : int'(stride_log2));
    for (int tr = 0; tr <= int'(tc_row_max); tr++)
      for (int tc = 0; tc <= int'(tc_col_max); tc++) begin
        len = (tc == int'(tc_col_max) && tile_col_offset != 0) ? int'(tile_col_offset) : TILE_LEN;
        msk = '1;
        if (tr == int'(tc_row_max) && tile_row_offset != 0)
          for (int b = 0; b < COL; b++) msk[b] = (b < int'(tile_row_offset));
        for (int oc = 0; oc < ocn; oc++)
          for (int kr = 0; kr < k; kr++)
            for (int kc = 0; kc < k; kc++)
              for (int ic = 0; ic < icn; ic++) begin
                pass_t p;
                p.len = len; p.kr = kr; p.kc = kc; p.msk = msk;
                p.tap_end  = (ic == icn - 1);
                p.oc_end   = p.tap_end && kr == k - 1 && kc == k - 1;
                p.tile_end = p.oc_end && oc == ocn - 1;
                p.conv_end = p.tile_end && tc == int'(tc_col_max) && tr == int'(tc_row_max);
                passes.push_back(p);
              end
      end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock: drive inputs, compare every output against the model, advance the model.
  task automatic cycle(input bit r, input bit s, input bit d);
    logic e_ifm, e_wgt, e_ic, e_tap, e_oc, e_conv, e_busy, last;
    logic [1:0] e_kr, e_kc;
    logic [COL-1:0] e_pv, nx_pv;
    logic [31:0] e_perf;
    logic [50:0] got, exp;
    pass_t c;
    @(negedge clk);
    rst = r; start_conv = s; data_ready = d;
    #1;
    {e_ifm, e_wgt, e_ic, e_tap, e_oc, e_conv, last} = '0;
    e_kr = 2'd0; e_kc = 2'd0; e_pv = m_pv; e_busy = m_busy; nx_pv = '0;
    if (m_busy) begin
      c = passes[m_p];
      e_kr = 2'(c.kr); e_kc = 2'(c.kc);
      if (!m_stream) begin
        e_wgt = d; e_ifm = d;
      end else begin
        last   = (m_px == c.len - 1);
        e_ifm  = d && !last;
        e_ic   = d && last;
        e_tap  = e_ic && c.tap_end;
        e_oc   = e_ic && c.oc_end;
        e_conv = e_ic && c.conv_end;
        if (d && (m_px % step) == 0) nx_pv = c.msk;
      end
    end
    e_perf = PERF ? 32'(m_stall) : 32'd0;
    got = {ifm_read, wgt_read, pvalid, ker_row, ker_col, ic_done, tap_done, oc_done, conv_done, busy, perf_stall_cnt};
    exp = {e_ifm, e_wgt, e_pv, e_kr, e_kc, e_ic, e_tap, e_oc, e_conv, e_busy, e_perf};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle t=%0t got ifm=%b wgt=%b pv=%h kr=%0d kc=%0d ic=%b tap=%b oc=%b conv=%b busy=%b perf=%0d expected ifm=%b wgt=%b pv=%h kr=%0d kc=%0d ic=%b tap=%b oc=%b conv=%b busy=%b perf=%0d",
        $time, ifm_read, wgt_read, pvalid, ker_row, ker_col, ic_done, tap_done, oc_done, conv_done, busy, perf_stall_cnt,
        e_ifm, e_wgt, e_pv, e_kr, e_kc, e_ic, e_tap, e_oc, e_conv, e_busy, e_perf);
    end
    n_busy += int'(busy); n_ifm += int'(ifm_read); n_wgt += int'(wgt_read);
    n_pv   += int'(pvalid != '0); n_part += int'(pvalid != '0 && pvalid != '1);
    n_tap  += int'(tap_done); n_oc += int'(oc_done); n_conv += int'(conv_done);
    if (r) begin
      m_busy = 1'b0; m_stream = 1'b0; m_pv = '0; m_stall = 0;
    end else begin
      m_pv = nx_pv;
      if (!m_busy) begin
        if (s) begin build(); m_busy = 1'b1; m_stream = 1'b0; m_p = 0; m_px = 0; m_stall = 0; end
      end else if (!d) m_stall++;
      else if (!m_stream) m_stream = 1'b1;
      else if (m_px == c.len - 1) begin
        m_px = 0; m_stream = 1'b0;
        if (c.conv_end) m_busy = 1'b0; else m_p++;
      end else m_px++;
    end
  endtask

  task automatic clear_tally();
    {n_busy, n_ifm, n_wgt, n_pv, n_part, n_tap, n_oc, n_conv} = '0;
  endtask

  task automatic set_cfg(input vec_t v);
    chi = v.chi; cho = v.cho; ker_size = v.ker; stride_log2 = v.sl;
    tc_row_max = v.trm; tc_col_max = v.tcm; tile_row_offset = v.tro; tile_col_offset = v.tco;
  endtask

  task automatic run_layer(input int pct, input int budget);
    int n = 0;
    cycle(1'b0, 1'b1, 1'b1);
    while (m_busy && n < budget) begin
      cycle(1'b0, ($urandom_range(7) == 0), ($urandom_range(99) < pct));
      n++;
    end
    cycle(1'b0, 1'b0, 1'b1);
    check_int("layer_terminates", busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int cyc, stl, first_ic;
    bit d;
    vecs[0] = '{4'd1, 4'd1, 2'd3, 2'd0, 6'd0, 6'd0, 4'd0, 4'd0, 612, 576, 36, 576, 0, 18, 2};
    vecs[1] = '{4'd1, 4'd1, 2'd3, 2'd1, 6'd0, 6'd1, 4'd0, 4'd5, 828, 756, 72, 396, 0, 36, 4};
    vecs[2] = '{4'd1, 4'd1, 2'd1, 2'd0, 6'd1, 6'd0, 4'd3, 4'd0, 136, 128, 8, 128, 64, 4, 4};
    vecs[3] = '{4'd0, 4'd1, 2'd0, 2'd3, 6'd0, 6'd0, 4'd0, 4'd0, 1088, 1024, 64, 256, 0, 2, 2};
    vecs[4] = '{4'd2, 4'd1, 2'd2, 2'd2, 6'd1, 6'd1, 4'd0, 4'd1, 1216, 1088, 128, 320, 0, 32, 8};
    m_busy = 1'b0; m_stream = 1'b0; m_pv = '0; m_stall = 0; m_p = 0; m_px = 0; step = 1;
    rst = 1'b1; start_conv = 1'b0; data_ready = 1'b0;
    set_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    rst = 1'b0; data_ready = 1'b1;
    #1;
    check_int("reset_busy", busy, 0);
    check_int("reset_pvalid", pvalid, 0);
    check_int("reset_ifm_read", ifm_read, 0);
    check_int("reset_wgt_read", wgt_read, 0);
    check_int("reset_conv_done", conv_done, 0);
    check_int("reset_perf", perf_stall_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i]);
      clear_tally();
      run_layer(100, 5000);
      check_int($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].busy);
      check_int($sformatf("v%0d_ifm_reads", i), n_ifm, vecs[i].ifm);
      check_int($sformatf("v%0d_wgt_reads", i), n_wgt, vecs[i].wgt);
      check_int($sformatf("v%0d_pvalid_cycles", i), n_pv, vecs[i].pv);
      check_int($sformatf("v%0d_pvalid_masked", i), n_part, vecs[i].part);
      check_int($sformatf("v%0d_tap_done", i), n_tap, vecs[i].tap);
      check_int($sformatf("v%0d_oc_done", i), n_oc, vecs[i].oc);
      check_int($sformatf("v%0d_conv_done", i), n_conv, 1);
    end

    // Three-cycle stall at pixel column 7 of the first pass.
    set_cfg('{4'd1, 4'd1, 2'd1, 2'd0, 6'd0, 6'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0});
    cycle(1'b0, 1'b1, 1'b1);
    cyc = 0; stl = 0; first_ic = -1;
    while (m_busy && cyc < 400) begin
      d = !(m_stream && m_px == 7 && stl < 3);
      if (!d) stl++;
      cycle(1'b0, 1'b0, d);
      cyc++;
      if (ic_done && first_ic < 0) first_ic = cyc;
    end
    cycle(1'b0, 1'b0, 1'b1);
    check_int("stall_pass_len", first_ic, 20);
    check_int("stall_perf_cnt", perf_stall_cnt, PERF ? 3 : 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check_int("perf_hold_idle", perf_stall_cnt, PERF ? 3 : 0);

    // Reset at pixel column 9 of the fourth pass, then a clean restart.
    set_cfg('{4'd1, 4'd1, 2'd2, 2'd0, 6'd0, 6'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0});
    cycle(1'b0, 1'b1, 1'b1);
    cyc = 0;
    while (!(m_stream && m_p == 3 && m_px == 9) && cyc < 400) begin cycle(1'b0, 1'b0, 1'b1); cyc++; end
    check_int("pre_reset_ker_col", ker_col, 1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_int("post_reset_busy", busy, 0);
    check_int("post_reset_pvalid", pvalid, 0);
    check_int("post_reset_ic_done", ic_done, 0);
    check_int("post_reset_conv_done", conv_done, 0);
    cycle(1'b0, 1'b1, 1'b1);
    check_int("restart_ker_col", ker_col, 0);
    cyc = 0; first_ic = -1;
    while (m_busy && cyc < 2000) begin
      cycle(1'b0, 1'b0, 1'b1);
      cyc++;
      if (ic_done && first_ic < 0) first_ic = cyc;
    end
    cycle(1'b0, 1'b0, 1'b1);
    check_int("restart_first_pass", first_ic, 17);

    // Randomized layers with random data_ready and stray start pulses.
    for (int it = 0; it < 6; it++) begin
      chi = 4'($urandom_range(1, 2)); cho = 4'($urandom_range(1, 2));
      ker_size = 2'($urandom_range(0, 2)); stride_log2 = 2'($urandom_range(0, 3));
      tc_row_max = 6'($urandom_range(0, 1)); tc_col_max = 6'($urandom_range(0, 1));
      tile_row_offset = 4'($urandom_range(0, 10)); tile_col_offset = 4'($urandom_range(0, 15));
      run_layer(70, 20000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
